// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queue in a small in-order FIFO and are sent LSB-first.
// TX is registered from the current state, so the line lags the FSM by one clock.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_PERIOD - 1);
  localparam logic [AW:0]   LEVEL_FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          push, pop, bit_end, fifo_empty;

  assign in_ready   = (level_q != LEVEL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid && in_ready;
  assign bit_end    = (cnt_q == CNT_LAST);
  assign fifo_level = level_q;
  assign TX         = tx_q;

  // Storage has no reset; only the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Next-state logic; the baud counter restarts at zero on every frame start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != IDLE) || !fifo_empty;
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model checked every cycle, a line decoder,
// and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CLK_HZ = 96;
  localparam int BAUD   = 12;
  localparam int DEPTH  = 4;
  localparam int BP     = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       TX;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int failures = 0;

  uart_tx #(.CLOCK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .TX(TX), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a queue of bytes plus the time elapsed inside the current frame.
  logic [7:0] mq[$];
  logic       m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_tx = 1'b1;

  always @(posedge clk or negedge resetn) begin
    bit can_push;
    if (!resetn) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
      m_tx  = 1'b1;
    end else begin
      if (!m_act)              m_tx = 1'b1;
      else if (m_t < BP)       m_tx = 1'b0;
      else if (m_t < 9 * BP)   m_tx = m_byte[m_t / BP - 1];
      else                     m_tx = 1'b1;
      can_push = (mq.size() < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == 10 * BP) m_act = 1'b0;
      end
      if (!m_act && mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_t    = 0;
      end
      if (in_valid && can_push) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    check("tx", TX, m_tx);
    check("busy", busy, (m_act || mq.size() != 0) ? 1 : 0);
    check("level", fifo_level, 32'(mq.size()));
    check("in_ready", in_ready, (mq.size() != DEPTH) ? 1 : 0);
  end

  // Line decoder standing in for the receiver at the far end.
  logic [7:0] rx_q[$];
  time        rx_t[$];
  initial begin
    logic [7:0] b;
    time        st;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        st = $time;
        repeat (BP / 2) @(negedge clk);
        check("rx_start", TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = TX;
        end
        repeat (BP) @(negedge clk);
        check("rx_stop", TX, 1);
        rx_q.push_back(b);
        rx_t.push_back(st);
        $display("rx byte %02h start %0t", b, st);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output time t_acc, output int waited);
    logic r;
    r = 1'b0;
    waited = 0;
    t_acc = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!r && waited < 2000) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      t_acc = $time;
      #1;
      waited++;
    end
    in_valid = 1'b0;
    check("push_accept", r, 1);
    $display("push %02h accepted %0t after %0d cycles", b, t_acc, waited);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act || mq.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", (m_act || mq.size() != 0) ? 0 : 1, 1);
    repeat (2 * BP) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], exp[i]);
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_frame_time(input int t, output bit found);
    int n;
    n = 0;
    found = 0;
    while (n < 2000 && !found) begin
      if (m_act && m_t == t) found = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("frame_point", found, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    time t_acc, t_dummy;
    int  waited;
    bit  found;
    logic [7:0] burst[$];

    resetn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", TX, 1);
    check("reset_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_level", fifo_level, 0);
    resetn = 1'b1;

    // Long idle: line must stay high.
    repeat (5000) @(posedge clk);
    #1;
    check("idle_tx", TX, 1);

    // Single byte: start bit low two clocks after acceptance.
    push_byte(8'h31, t_acc, waited);
    wait_idle();
    check("latency", (rx_t.size() > 0) ? 32'(rx_t[0] - t_acc) : 0, 25);
    check("single_busy", busy, 0);
    check_rx("single", '{8'h31});

    // Burst: five accepted without stall, sixth waits for the first pop.
    push_byte(8'h00, t_dummy, waited);
    push_byte(8'hFF, t_dummy, waited);
    push_byte(8'h55, t_dummy, waited);
    push_byte(8'hA5, t_dummy, waited);
    push_byte(8'h5A, t_dummy, waited);
    @(negedge clk);
    check("burst_level", fifo_level, 4);
    check("burst_full", in_ready, 0);
    push_byte(8'hC3, t_dummy, waited);
    check("burst_blocked", (waited > 1) ? 1 : 0, 1);
    wait_idle();
    for (int i = 1; i < rx_t.size(); i++)
      check("frame_spacing", 32'(rx_t[i] - rx_t[i-1]), 800);
    burst = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h5A, 8'hC3};
    check_rx("burst", burst);

    // Loopback of "12345".
    for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i), t_dummy, waited);
    wait_idle();
    check_rx("loop", '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35});

    // Push coinciding with the pop at the end of a stop bit, level 2.
    push_byte(8'hA1, t_dummy, waited);
    push_byte(8'hB2, t_dummy, waited);
    push_byte(8'hC3, t_dummy, waited);
    wait_frame_time(10 * BP - 1, found);
    check("pp_level_before", fifo_level, 2);
    in_valid = 1'b1;
    in_data  = 8'hD4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pp_level_after", fifo_level, 2);
    check("pp_busy", busy, 1);
    wait_idle();
    check_rx("pushpop", '{8'hA1, 8'hB2, 8'hC3, 8'hD4});

    // Reset during bit 3 of 0xAA with another byte queued.
    push_byte(8'hAA, t_dummy, waited);
    push_byte(8'h55, t_dummy, waited);
    wait_frame_time(4 * BP + BP / 2, found);
    check("mid_tx_before", TX, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_tx", TX, 1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (12 * BP) @(posedge clk);
    #1;
    rx_q.delete();
    rx_t.delete();
    push_byte(8'h0F, t_dummy, waited);
    wait_idle();
    check_rx("after_rst", '{8'h0F});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
